// File: rtl/edge_detector.sv
// Per-bit edge detector: compares the live input vector against a clock-enabled
// history register and reports rising, falling and either-edge transitions.
module edge_detector #(
    parameter int WID = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ce,
    input  logic [WID-1:0] i,
    output logic [WID-1:0] pe,
    output logic [WID-1:0] ne,
    output logic [WID-1:0] ee
);

    logic [WID-1:0] r_ed;
    logic [WID-1:0] w_pe;
    logic [WID-1:0] w_ne;
    logic [WID-1:0] w_ee;

    // History register: cleared by synchronous active-low reset, loaded when enabled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ed <= {WID{1'b0}};
        end else if (ce) begin
            r_ed <= i;
        end else begin
            r_ed <= r_ed;
        end
    end

    // Raw edge terms from the live input against the held history.
    always_comb begin
        w_pe = i & ~r_ed;
        w_ne = ~i & r_ed;
        w_ee = i ^ r_ed;
    end

    // Outputs stay combinational so an edge is visible in the cycle it appears;
    // reset gates them immediately, ahead of the history clearing on the next edge.
    always_comb begin
        pe = {WID{1'b0}};
        ne = {WID{1'b0}};
        ee = {WID{1'b0}};
        if (rst) begin
            pe = w_pe;
            ne = w_ne;
            ee = w_ee;
        end else begin
            pe = {WID{1'b0}};
            ne = {WID{1'b0}};
            ee = {WID{1'b0}};
        end
    end

endmodule

// File: tb/tb_edge_detector.sv
// Self-checking bench for edge_detector (WID=8): directed vector table,
// hand-written mid-cycle sequences, then randomized stimulus against a reference model.
module tb_edge_detector;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         ce;
    logic [W-1:0] i;
    logic [W-1:0] pe;
    logic [W-1:0] ne;
    logic [W-1:0] ee;

    int n_cmp;
    int n_bad;

    logic [W-1:0] m_hist;

    typedef struct {
        logic         rst;
        logic         ce;
        logic [W-1:0] i;
        logic [W-1:0] pe;
        logic [W-1:0] ne;
        logic [W-1:0] ee;
    } vec_t;

    vec_t tbl[30];

    edge_detector #(.WID(W)) dut (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .i   (i),
        .pe  (pe),
        .ne  (ne),
        .ee  (ee)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: an edge is a bit whose live value differs from the last
    // value captured while enabled; nothing is reported while in reset.
    task automatic model_exp(input logic r, input logic [W-1:0] d, input logic [W-1:0] h,
                             output logic [W-1:0] xp, output logic [W-1:0] xn,
                             output logic [W-1:0] xe);
        xp = '0; xn = '0; xe = '0;
        if (r) begin
            for (int b = 0; b < W; b++) begin
                if (d[b] == 1'b1 && h[b] == 1'b0) xp[b] = 1'b1;
                if (d[b] == 1'b0 && h[b] == 1'b1) xn[b] = 1'b1;
                if (d[b] != h[b]) xe[b] = 1'b1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [W-1:0] xp,
                       input logic [W-1:0] xn, input logic [W-1:0] xe);
        n_cmp++;
        if (pe !== xp || ne !== xn || ee !== xe) begin
            n_bad++;
            $display("FAIL %s: pe=%h ne=%h ee=%h, expected pe=%h ne=%h ee=%h",
                     name, pe, ne, ee, xp, xn, xe);
        end
        n_cmp++;
        if ((pe & ne) !== '0 || ee !== (pe | ne)) begin
            n_bad++;
            $display("FAIL %s_invariant: pe=%h ne=%h ee=%h, expected pe&ne=0 and ee=pe|ne",
                     name, pe, ne, ee);
        end
    endtask

    task automatic chk_model(input string name);
        logic [W-1:0] xp, xn, xe;
        model_exp(rst, i, m_hist, xp, xn, xe);
        chk(name, xp, xn, xe);
    endtask

    // Finish the current cycle: wait for the edge and advance the model history.
    task automatic clock_step();
        @(posedge clk);
        if (!rst) m_hist = '0;
        else if (ce) m_hist = i;
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        m_hist = '0;

        //          rst   ce    i      pe     ne     ee
        tbl[0]  = '{1'b0, 1'b1, 8'h01, 8'h00, 8'h00, 8'h00};
        tbl[1]  = '{1'b0, 1'b1, 8'h01, 8'h00, 8'h00, 8'h00};
        tbl[2]  = '{1'b0, 1'b1, 8'h01, 8'h00, 8'h00, 8'h00};
        tbl[3]  = '{1'b1, 1'b1, 8'h01, 8'h01, 8'h00, 8'h01};
        tbl[4]  = '{1'b1, 1'b1, 8'h01, 8'h00, 8'h00, 8'h00};
        tbl[5]  = '{1'b1, 1'b1, 8'h00, 8'h00, 8'h01, 8'h01};
        tbl[6]  = '{1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[7]  = '{1'b1, 1'b1, 8'h01, 8'h01, 8'h00, 8'h01};
        tbl[8]  = '{1'b1, 1'b1, 8'h01, 8'h00, 8'h00, 8'h00};
        tbl[9]  = '{1'b1, 1'b1, 8'h00, 8'h00, 8'h01, 8'h01};
        tbl[10] = '{1'b1, 1'b0, 8'h01, 8'h01, 8'h00, 8'h01};
        tbl[11] = '{1'b1, 1'b0, 8'h01, 8'h01, 8'h00, 8'h01};
        tbl[12] = '{1'b1, 1'b0, 8'h01, 8'h01, 8'h00, 8'h01};
        tbl[13] = '{1'b1, 1'b0, 8'h01, 8'h01, 8'h00, 8'h01};
        tbl[14] = '{1'b1, 1'b1, 8'h01, 8'h01, 8'h00, 8'h01};
        tbl[15] = '{1'b1, 1'b1, 8'h01, 8'h00, 8'h00, 8'h00};
        tbl[16] = '{1'b1, 1'b1, 8'h0F, 8'h0E, 8'h00, 8'h0E};
        tbl[17] = '{1'b1, 1'b1, 8'h3C, 8'h30, 8'h03, 8'h33};
        tbl[18] = '{1'b1, 1'b1, 8'h00, 8'h00, 8'h3C, 8'h3C};
        tbl[19] = '{1'b1, 1'b1, 8'h01, 8'h01, 8'h00, 8'h01};
        tbl[20] = '{1'b1, 1'b1, 8'h00, 8'h00, 8'h01, 8'h01};
        tbl[21] = '{1'b1, 1'b1, 8'h01, 8'h01, 8'h00, 8'h01};
        tbl[22] = '{1'b1, 1'b1, 8'h00, 8'h00, 8'h01, 8'h01};
        tbl[23] = '{1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, 8'h00};
        tbl[24] = '{1'b1, 1'b0, 8'hFF, 8'hFF, 8'h00, 8'hFF};
        tbl[25] = '{1'b0, 1'b1, 8'hAA, 8'h00, 8'h00, 8'h00};
        tbl[26] = '{1'b1, 1'b1, 8'hAA, 8'hAA, 8'h00, 8'hAA};
        tbl[27] = '{1'b1, 1'b1, 8'hAA, 8'h00, 8'h00, 8'h00};
        tbl[28] = '{1'b0, 1'b1, 8'h55, 8'h00, 8'h00, 8'h00};
        tbl[29] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00};

        for (int k = 0; k < 30; k++) begin
            rst = tbl[k].rst;
            ce  = tbl[k].ce;
            i   = tbl[k].i;
            @(negedge clk);
            chk($sformatf("vec%0d", k), tbl[k].pe, tbl[k].ne, tbl[k].ee);
            clock_step();
        end

        // Mid-cycle glitches and reset gating, history held at 0 with ce low.
        rst = 1'b1; ce = 1'b0; i = 8'hF0; #1;
        chk("glitch_f0", 8'hF0, 8'h00, 8'hF0);
        i = 8'h0F; #1;
        chk("glitch_0f", 8'h0F, 8'h00, 8'h0F);
        i = 8'h00; #1;
        chk("glitch_00", 8'h00, 8'h00, 8'h00);
        i = 8'hFF; #1;
        chk("pulse_ff", 8'hFF, 8'h00, 8'hFF);
        rst = 1'b0; #1;
        chk("rst_gate", 8'h00, 8'h00, 8'h00);
        rst = 1'b1; #1;
        chk("rst_ungate", 8'hFF, 8'h00, 8'hFF);
        clock_step();

        // Randomized stimulus against the reference model.
        for (int k = 0; k < 400; k++) begin
            rst = ($urandom_range(0, 15) != 0);
            ce  = ($urandom_range(0, 3) != 0);
            i   = ($urandom_range(0, 1) != 0) ? m_hist ^ W'($urandom_range(0, 255))
                                               : W'($urandom_range(0, 255));
            @(negedge clk);
            chk_model($sformatf("rand%0d", k));
            clock_step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
